sdf_bf2_stage: RTL and testbench



---
 rtl/sdf_bf2_stage_if.sv | 22 ++
 rtl/sdf_bf2_stage.sv | 60 ++++++
 tb/tb_sdf_bf2_stage.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sdf_bf2_stage_if.sv
// sdf_bf2_stage_if: complex sample stream into the SDF butterfly stage and tagged results out of it.
interface sdf_bf2_stage_if #(
    parameter int WIDTH = 13,
    parameter int INDEX = 4
);
    logic                    in_valid;
    logic signed [WIDTH-1:0] in_re;
    logic signed [WIDTH-1:0] in_im;
    logic                    out_valid;
    logic signed [WIDTH:0]   out_re;
    logic signed [WIDTH:0]   out_im;
    logic                    out_sel;
    logic [INDEX-1:0]        out_idx;
    modport master (
        output in_valid, in_re, in_im,
        input  out_valid, out_re, out_im, out_sel, out_idx
    );
    modport slave (
        input  in_valid, in_re, in_im,
        output out_valid, out_re, out_im, out_sel, out_idx
    );
endinterface

// File: rtl/sdf_bf2_stage.sv
// sdf_bf2_stage: radix-2 single-path delay-feedback butterfly; emits sums of a block,
// then its differences while the next block fills the feedback delay line.
module sdf_bf2_stage #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 16,
    parameter int INDEX = 4
) (
    input logic            clk,
    input logic            rst,
    sdf_bf2_stage_if.slave bus
);
    localparam int W1 = WIDTH + 1;
    logic [INDEX:0]        cnt;
    logic                  pending;
    logic [2*W1-1:0]       mem [DEPTH];
    logic                  phase;
    logic [INDEX-1:0]      ptr;
    logic signed [W1-1:0]  x_re, x_im, d_re, d_im;
    assign phase = cnt[INDEX];
    assign ptr   = cnt[INDEX-1:0];
    assign x_re  = {bus.in_re[WIDTH-1], bus.in_re};
    assign x_im  = {bus.in_im[WIDTH-1], bus.in_im};
    assign {d_re, d_im} = mem[ptr];
    // Fill phase stores the new sample; butterfly phase parks the difference for later.
    always_ff @(posedge clk) begin
        if (bus.in_valid)
            mem[ptr] <= phase ? {d_re - x_re, d_im - x_im} : {x_re, x_im};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            pending       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_re    <= '0;
            bus.out_im    <= '0;
            bus.out_sel   <= 1'b0;
            bus.out_idx   <= '0;
        end else begin
            bus.out_valid <= 1'b0;
            if (bus.in_valid) begin
                cnt <= cnt + 1'b1;
                if (&cnt)
                    pending <= 1'b1;
                if (phase) begin
                    bus.out_valid <= 1'b1;
                    bus.out_re    <= d_re + x_re;
                    bus.out_im    <= d_im + x_im;
                    bus.out_sel   <= 1'b0;
                    bus.out_idx   <= ptr;
                end else if (pending) begin
                    bus.out_valid <= 1'b1;
                    bus.out_re    <= d_re;
                    bus.out_im    <= d_im;
                    bus.out_sel   <= 1'b1;
                    bus.out_idx   <= ptr;
                end
            end
        end
    end
endmodule

// File: tb/tb_sdf_bf2_stage.sv
// tb_sdf_bf2_stage: directed checks of the SDF butterfly stage against hand-derived results.
module tb_sdf_bf2_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    sdf_bf2_stage_if #(.WIDTH(13), .INDEX(4)) bus ();
    sdf_bf2_stage #(.WIDTH(13), .DEPTH(16), .INDEX(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic step(input logic v, input int re, input int im);
        bus.in_valid = v;
        bus.in_re    = 13'(re);
        bus.in_im    = 13'(im);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1, 100 + i, -5);
            n_checks++;
            if ({bus.out_valid, bus.out_sel, bus.out_idx, bus.out_re, bus.out_im} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d got v=%b sel=%b idx=%0d re=%0d im=%0d want all 0",
                         i, bus.out_valid, bus.out_sel, bus.out_idx, bus.out_re, bus.out_im);
            end
        end
        rst = 1'b0;
        step(1, 1, 1);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_valid got out_valid=%b want 0", bus.out_valid);
        end
    endtask

    // Ramp 0..31 then 16 zeros; optional bubble on every third cycle with junk data.
    task automatic run_ramp(input string name, input bit bubbles);
        int n = 0;
        int c = 0;
        logic v, ev, es;
        logic [3:0] ei = '0;
        int er = 0;
        int em = 0;
        es = 1'b0;
        while (n < 48) begin
            v = !(bubbles && (c % 3 == 2));
            step(v, v ? (n < 32 ? n : 0) : 999, v ? 0 : -77);
            ev = 1'b0;
            if (v) begin
                if (n >= 16 && n < 32) begin
                    ev = 1'b1; es = 1'b0; ei = 4'(n - 16); er = 2 * (n - 16) + 16;
                end else if (n >= 32) begin
                    ev = 1'b1; es = 1'b1; ei = 4'(n - 32); er = -16;
                end
                n++;
            end
            c++;
            n_checks++;
            if ({bus.out_valid, bus.out_sel, bus.out_idx} !== {ev, es, ei} ||
                $signed(bus.out_re) !== er || $signed(bus.out_im) !== em) begin
                n_fail++;
                $display("FAIL %s cyc=%0d got v=%b sel=%b idx=%0d re=%0d im=%0d want v=%b sel=%b idx=%0d re=%0d im=%0d",
                         name, c, bus.out_valid, bus.out_sel, bus.out_idx, $signed(bus.out_re), $signed(bus.out_im),
                         ev, es, ei, er, em);
            end
        end
    endtask

    task automatic test_ramp();
        do_reset();
        run_ramp("ramp", 1'b0);
    endtask

    task automatic test_bubbles();
        do_reset();
        run_ramp("bubbles", 1'b1);
    endtask

    task automatic test_reset_mid_block();
        do_reset();
        for (int i = 0; i < 20; i++) step(1, i, 0);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1, 7, 7);
            n_checks++;
            if ({bus.out_valid, bus.out_sel, bus.out_idx, bus.out_re, bus.out_im} !== '0) begin
                n_fail++;
                $display("FAIL midreset_outputs cyc=%0d got v=%b sel=%b idx=%0d re=%0d im=%0d want all 0",
                         i, bus.out_valid, bus.out_sel, bus.out_idx, bus.out_re, bus.out_im);
            end
        end
        rst = 1'b0;
        run_ramp("midreset_ramp", 1'b0);
    endtask

    task automatic test_extremes();
        int re, im, er, em;
        logic es;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            re = i < 48 ? 4095 : (i < 64 ? -4096 : 0);
            im = i < 48 ? -4096 : (i < 64 ? 4095 : 0);
            step(1, re, im);
            es = (i / 16) % 2 == 0;
            er = i < 32 ? 8190 : i < 48 ? 0 : i < 64 ? -1 : 8191;
            em = i < 32 ? -8192 : i < 48 ? 0 : i < 64 ? -1 : -8191;
            n_checks++;
            if (i < 16 ? bus.out_valid !== 1'b0 :
                ({bus.out_valid, bus.out_sel, bus.out_idx} !== {1'b1, es, 4'(i % 16)} ||
                 $signed(bus.out_re) !== er || $signed(bus.out_im) !== em)) begin
                n_fail++;
                $display("FAIL extremes i=%0d got v=%b sel=%b idx=%0d re=%0d im=%0d want v=%b sel=%b idx=%0d re=%0d im=%0d",
                         i, bus.out_valid, bus.out_sel, bus.out_idx, $signed(bus.out_re), $signed(bus.out_im),
                         i >= 16, es, i % 16, er, em);
            end
        end
    endtask

    task automatic test_back_to_back();
        int xr[112], xi[112];
        int blk, pos, er, em;
        logic es;
        for (int i = 0; i < 112; i++) begin
            xr[i] = i < 96 ? int'($urandom_range(0, 8191)) - 4096 : 0;
            xi[i] = i < 96 ? int'($urandom_range(0, 8191)) - 4096 : 0;
        end
        do_reset();
        for (int i = 0; i < 112; i++) begin
            step(1, xr[i], xi[i]);
            blk = i / 32;
            pos = i % 32;
            es = pos < 16;
            if (pos >= 16) begin
                er = xr[i - 16] + xr[i];
                em = xi[i - 16] + xi[i];
            end else if (blk > 0) begin
                er = xr[i - 32] - xr[i - 16];
                em = xi[i - 32] - xi[i - 16];
            end
            n_checks++;
            if (i < 16 ? bus.out_valid !== 1'b0 :
                ({bus.out_valid, bus.out_sel, bus.out_idx} !== {1'b1, es, 4'(pos % 16)} ||
                 $signed(bus.out_re) !== er || $signed(bus.out_im) !== em)) begin
                n_fail++;
                $display("FAIL back_to_back i=%0d got v=%b sel=%b idx=%0d re=%0d im=%0d want sel=%b idx=%0d re=%0d im=%0d",
                         i, bus.out_valid, bus.out_sel, bus.out_idx, $signed(bus.out_re), $signed(bus.out_im),
                         es, pos % 16, er, em);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_re    = '0;
        bus.in_im    = '0;
        test_reset();
        test_ramp();
        test_extremes();
        test_bubbles();
        test_reset_mid_block();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
